// File: rtl/alu16_serial_if.sv
// Start/Busy/Done handshake and operand/result bus between a sequencer and the serial ALU.
interface alu16_serial_if #(
    parameter int unsigned SIZE = 16
);
    logic            start;
    logic [SIZE-1:0] a;
    logic [SIZE-1:0] b;
    logic [1:0]      s;
    logic            ci;
    logic            busy;
    logic            done;
    logic [SIZE-1:0] r;
    logic            co;
    logic            v;
    logic            z;

    modport master (
        output start, a, b, s, ci,
        input  busy, done, r, co, v, z
    );

    modport slave (
        input  start, a, b, s, ci,
        output busy, done, r, co, v, z
    );
endinterface

// File: rtl/alu16_serial.sv
// Digit-serial ALU: one 2-bit slice reused over SIZE/2 clocks for ADD/SUB/AND/OR,
// with a registered inter-digit carry and results published only on completion.
module alu16_serial #(
    parameter int unsigned SIZE = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    alu16_serial_if.slave bus
);
    localparam int unsigned DIGITS = SIZE / 2;
    localparam int unsigned CNT_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t            state_q, state_d;
    logic              accept;
    logic              last_digit;

    logic [SIZE-1:0]   a_q;
    logic [SIZE-1:0]   b_q;
    logic [1:0]        op_q;
    logic              carry_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [SIZE-1:0]   res_sr_q;

    logic [1:0]        dig;
    logic              c1;
    logic              c2;
    logic [SIZE+1:0]   res_ext;
    logic [SIZE-1:0]   res_next;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state; a request is taken only when no operation is in flight
    always_comb begin
        state_d    = state_q;
        accept     = 1'b0;
        last_digit = (cnt_q == CNT_W'(DIGITS - 1));
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    accept  = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (last_digit) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.start) begin
                    accept  = 1'b1;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // One 2-bit slice on the low digit of the shifting operands
    always_comb begin
        dig = 2'b00;
        c1  = 1'b0;
        c2  = 1'b0;
        case (op_q)
            OP_AND: dig = a_q[1:0] & b_q[1:0];
            OP_OR:  dig = a_q[1:0] | b_q[1:0];
            default: begin
                {c1, dig[0]} = {1'b0, a_q[0]} + {1'b0, b_q[0]} + {1'b0, carry_q};
                {c2, dig[1]} = {1'b0, a_q[1]} + {1'b0, b_q[1]} + {1'b0, c1};
            end
        endcase
        res_ext  = {dig, res_sr_q};
        res_next = res_ext[SIZE+1:2];
    end

    // Operand capture, digit stepping and result publication
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= 2'b00;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            res_sr_q <= '0;
            bus.r    <= '0;
            bus.co   <= 1'b0;
            bus.v    <= 1'b0;
            bus.z    <= 1'b0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
        end else begin
            bus.busy <= (state_d == ST_RUN);
            bus.done <= (state_d == ST_DONE);
            if (accept) begin
                a_q     <= bus.a;
                b_q     <= (bus.s == OP_SUB) ? ~bus.b : bus.b;
                op_q    <= bus.s;
                carry_q <= bus.ci;
                cnt_q   <= '0;
            end else if (state_q == ST_RUN) begin
                a_q      <= a_q >> 2;
                b_q      <= b_q >> 2;
                carry_q  <= c2;
                cnt_q    <= cnt_q + CNT_W'(1);
                res_sr_q <= res_next;
                if (last_digit) begin
                    bus.r  <= res_next;
                    bus.co <= ~op_q[1] & c2;
                    bus.v  <= ~op_q[1] & (c1 ^ c2);
                    bus.z  <= (res_next == '0);
                end
            end
        end
    end
endmodule
